// File: rtl/riscv_definitions.sv
// Shared definitions for the sequential ALU.
// alu_ops_t enumerates every ALU operation. Encodings 18..31 are
// deliberately left unassigned; the ALU answers them with result 0.
// The helper functions classify an opcode by the datapath that serves it.
package riscv_definitions;

   typedef enum logic [4:0] {
      ADD    = 5'd0,
      SUB    = 5'd1,
      AND    = 5'd2,
      OR     = 5'd3,
      XOR    = 5'd4,
      SLT    = 5'd5,
      SLL    = 5'd6,
      SRL    = 5'd7,
      SRA    = 5'd8,
      SLTU   = 5'd9,
      MUL    = 5'd10,
      MULH   = 5'd11,
      MULHSU = 5'd12,
      MULHU  = 5'd13,
      DIV    = 5'd14,
      DIVU   = 5'd15,
      REM    = 5'd16,
      REMU   = 5'd17
   } alu_ops_t;

   // True for every opcode served by the iterative multiply/divide unit.
   function automatic logic is_muldiv_op(input alu_ops_t op);
      case (op)
         MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU: return 1'b1;
         default:                                       return 1'b0;
      endcase
   endfunction

   // True for the division and remainder opcodes only.
   function automatic logic is_div_op(input alu_ops_t op);
      case (op)
         DIV, DIVU, REM, REMU: return 1'b1;
         default:              return 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Iterative multiply/divide datapath: one bit per clock, XLEN clocks per op.
// Ports:
//   clk, rst_n   clock and asynchronous active-low reset (aborts any op)
//   start        load operands and begin; sampled on the accepting edge
//   op           MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
//   a, b         operands (dividend/multiplicand, divisor/multiplier)
//   done         high in the cycle whose edge completes the last step
//   result       final value, valid while done is high
// Both operations work on operand magnitudes held in a shared hi/lo register
// pair and fix the sign on the way out. Division by zero and signed overflow
// are handled by the caller and never reach this unit.
module muldiv_iter
   import riscv_definitions::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  alu_ops_t        op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic            done,
   output logic [XLEN-1:0] result
);

   localparam int SHAMT_W = $clog2(XLEN);

   logic               active_q, active_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [XLEN-1:0]    hi_q, hi_d;       // partial product high / remainder
   logic [XLEN-1:0]    lo_q, lo_d;       // multiplier bits / quotient bits
   logic [XLEN-1:0]    mag_q, mag_d;     // multiplicand / divisor magnitude
   logic               is_mul_q, is_mul_d;
   logic               want_hi_q, want_hi_d;   // MULH* or REM*: take hi half
   logic               neg_q, neg_d;           // negate the final answer

   logic [XLEN-1:0]    hi_n, lo_n;
   logic [XLEN:0]      sum_s, shifted_s, diff_s;
   logic [2*XLEN-1:0]  prod_s;
   logic [XLEN-1:0]    sel_s;
   logic               a_signed_s, b_signed_s, a_neg_s, b_neg_s;
   logic [XLEN-1:0]    a_mag_s, b_mag_s;

   assign done = active_q && (cnt_q == SHAMT_W'(XLEN - 1));

   // One shift-add or restoring-subtract step, plus final sign fix-up.
   always_comb begin
      sum_s     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mag_q} : {(XLEN+1){1'b0}});
      shifted_s = {hi_q, lo_q[XLEN-1]};
      diff_s    = shifted_s - {1'b0, mag_q};
      hi_n      = hi_q;
      lo_n      = lo_q;
      if (is_mul_q) begin
         hi_n = sum_s[XLEN:1];
         lo_n = {sum_s[0], lo_q[XLEN-1:1]};
      end else if (!diff_s[XLEN]) begin
         hi_n = diff_s[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], 1'b1};
      end else begin
         hi_n = shifted_s[XLEN-1:0];
         lo_n = {lo_q[XLEN-2:0], 1'b0};
      end
      // A signed product is negated as a whole; quotient/remainder individually.
      prod_s = neg_q ? ({(2*XLEN){1'b0}} - {hi_n, lo_n}) : {hi_n, lo_n};
      sel_s  = want_hi_q ? hi_n : lo_n;
      if (is_mul_q) begin
         result = want_hi_q ? prod_s[2*XLEN-1:XLEN] : prod_s[XLEN-1:0];
      end else begin
         result = neg_q ? ({XLEN{1'b0}} - sel_s) : sel_s;
      end
   end

   // Operand sign handling and next-state selection (load, step or hold).
   always_comb begin
      a_signed_s = (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
      b_signed_s = (op == MULH) || (op == DIV) || (op == REM);
      a_neg_s    = a_signed_s && a[XLEN-1];
      b_neg_s    = b_signed_s && b[XLEN-1];
      a_mag_s    = a_neg_s ? ({XLEN{1'b0}} - a) : a;
      b_mag_s    = b_neg_s ? ({XLEN{1'b0}} - b) : b;

      active_d  = active_q;
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      mag_d     = mag_q;
      is_mul_d  = is_mul_q;
      want_hi_d = want_hi_q;
      neg_d     = neg_q;
      if (start) begin
         active_d  = 1'b1;
         cnt_d     = {SHAMT_W{1'b0}};
         hi_d      = {XLEN{1'b0}};
         is_mul_d  = !is_div_op(op);
         want_hi_d = (op != MUL) && (op != DIV) && (op != DIVU);
         if (is_div_op(op)) begin
            lo_d  = a_mag_s;
            mag_d = b_mag_s;
            // Remainder follows the dividend; quotient follows a^b.
            neg_d = ((op == REM) || (op == REMU)) ? a_neg_s : (a_neg_s ^ b_neg_s);
         end else begin
            lo_d  = b_mag_s;
            mag_d = a_mag_s;
            neg_d = a_neg_s ^ b_neg_s;
         end
      end else if (active_q) begin
         hi_d     = hi_n;
         lo_d     = lo_n;
         cnt_d    = cnt_q + {{(SHAMT_W-1){1'b0}}, 1'b1};
         active_d = !done;
      end else begin
         active_d = 1'b0;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         active_q  <= 1'b0;
         cnt_q     <= {SHAMT_W{1'b0}};
         hi_q      <= {XLEN{1'b0}};
         lo_q      <= {XLEN{1'b0}};
         mag_q     <= {XLEN{1'b0}};
         is_mul_q  <= 1'b0;
         want_hi_q <= 1'b0;
         neg_q     <= 1'b0;
      end else begin
         active_q  <= active_d;
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         mag_q     <= mag_d;
         is_mul_q  <= is_mul_d;
         want_hi_q <= want_hi_d;
         neg_q     <= neg_d;
      end
   end

endmodule

// File: rtl/seq_alu.sv
// Sequential ALU with valid/ready handshakes on both sides.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   in_valid / in_ready    request handshake (ready only in IDLE)
//   operand_a, operand_b   operands, latched on accept
//   alu_op                 operation select
//   out_valid / out_ready  result handshake (valid only in DONE)
//   result, zero           registered result and result==0 flag
//   busy                   high while an iterative op is in CALC
// Single-cycle ops, divide-by-zero, signed overflow and undefined opcodes go
// IDLE -> DONE directly; multiply/divide spend XLEN cycles in CALC.
module seq_alu
   import riscv_definitions::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   input  alu_ops_t        alu_op,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            zero,
   output logic            busy
);

   localparam int SHAMT_W = $clog2(XLEN);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic            in_ready_q, in_ready_d;
   logic            out_valid_q, out_valid_d;
   logic            busy_q, busy_d;
   logic [XLEN-1:0] result_q, result_d;
   logic            zero_q, zero_d;

   logic [SHAMT_W-1:0] shamt_s;
   logic [XLEN-1:0]    quick_s, md_result_s;
   logic               div_zero_s, sgn_ovf_s, is_iter_s, accept_s, md_done_s;

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign busy      = busy_q;
   assign result    = result_q;
   assign zero      = zero_q;

   assign accept_s = in_valid && in_ready_q;

   // Single-cycle results, including the division fast paths.
   always_comb begin
      shamt_s    = operand_b[SHAMT_W-1:0];
      div_zero_s = (operand_b == {XLEN{1'b0}});
      sgn_ovf_s  = ((alu_op == DIV) || (alu_op == REM)) &&
                   (operand_a == {1'b1, {(XLEN-1){1'b0}}}) &&
                   (operand_b == {XLEN{1'b1}});
      is_iter_s  = is_muldiv_op(alu_op) && !(is_div_op(alu_op) && (div_zero_s || sgn_ovf_s));
      case (alu_op)
         ADD:  quick_s = operand_a + operand_b;
         SUB:  quick_s = operand_a - operand_b;
         AND:  quick_s = operand_a & operand_b;
         OR:   quick_s = operand_a | operand_b;
         XOR:  quick_s = operand_a ^ operand_b;
         SLT:  quick_s = {{(XLEN-1){1'b0}}, ($signed(operand_a) < $signed(operand_b))};
         SLTU: quick_s = {{(XLEN-1){1'b0}}, (operand_a < operand_b)};
         SLL:  quick_s = operand_a << shamt_s;
         SRL:  quick_s = operand_a >> shamt_s;
         SRA:  quick_s = $unsigned($signed(operand_a) >>> shamt_s);
         DIV, DIVU: begin
            if (div_zero_s) begin
               quick_s = {XLEN{1'b1}};
            end else if (sgn_ovf_s) begin
               quick_s = {1'b1, {(XLEN-1){1'b0}}};
            end else begin
               quick_s = {XLEN{1'b0}};
            end
         end
         REM, REMU: begin
            if (div_zero_s) begin
               quick_s = operand_a;
            end else begin
               quick_s = {XLEN{1'b0}};
            end
         end
         default: quick_s = {XLEN{1'b0}};
      endcase
   end

   muldiv_iter #(
      .XLEN (XLEN)
   ) u_muldiv (
      .clk    (clk),
      .rst_n  (rst_n),
      .start  (accept_s && is_iter_s),
      .op     (alu_op),
      .a      (operand_a),
      .b      (operand_b),
      .done   (md_done_s),
      .result (md_result_s)
   );

   // FSM next state and next values of all registered outputs.
   always_comb begin
      state_d     = state_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      busy_d      = busy_q;
      result_d    = result_q;
      zero_d      = zero_q;
      case (state_q)
         IDLE: begin
            if (accept_s) begin
               in_ready_d = 1'b0;
               if (is_iter_s) begin
                  state_d = CALC;
                  busy_d  = 1'b1;
               end else begin
                  state_d     = DONE;
                  out_valid_d = 1'b1;
                  result_d    = quick_s;
                  zero_d      = (quick_s == {XLEN{1'b0}});
               end
            end else begin
               state_d = IDLE;
            end
         end
         CALC: begin
            if (md_done_s) begin
               state_d     = DONE;
               busy_d      = 1'b0;
               out_valid_d = 1'b1;
               result_d    = md_result_s;
               zero_d      = (md_result_s == {XLEN{1'b0}});
            end else begin
               state_d = CALC;
            end
         end
         DONE: begin
            // Returning to IDLE takes the whole edge; no accept can coincide.
            if (out_ready) begin
               state_d     = IDLE;
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
            end else begin
               state_d = DONE;
            end
         end
         default: begin
            state_d     = IDLE;
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
         end
      endcase
   end

   // FSM state and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         result_q    <= {XLEN{1'b0}};
         zero_q      <= 1'b1;
      end else begin
         state_q     <= state_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         busy_q      <= busy_d;
         result_q    <= result_d;
         zero_q      <= zero_d;
      end
   end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (XLEN=32) with hand-computed expected values.
module tb_seq_alu;
   import riscv_definitions::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] operand_a;
   logic [31:0] operand_b;
   alu_ops_t    alu_op;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] result;
   logic        zero;
   logic        busy;

   int n_chk  = 0;
   int n_pass = 0;

   seq_alu #(.XLEN(32)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .operand_a (operand_a),
      .operand_b (operand_b),
      .alu_op    (alu_op),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .zero      (zero),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Issue one request, measure latency, check result/zero, then release it.
   // Called #1 after a rising edge.
   task automatic run_op(input string tag, input alu_ops_t op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
      int lat;
      operand_a = a;
      operand_b = b;
      alu_op    = op;
      in_valid  = 1'b1;
      check_eq({tag, " in_ready"}, {63'd0, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      if (exp_lat > 1) check_eq({tag, " busy"}, {63'd0, busy}, 64'd1);
      while (!out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check_eq({tag, " latency"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, " result"}, {32'd0, result}, {32'd0, exp_res});
      check_eq({tag, " zero"}, {63'd0, zero}, {63'd0, (exp_res == 32'd0)});
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq({tag, " release"}, {62'd0, out_valid, in_ready}, 64'd1);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      operand_a = 32'd0;
      operand_b = 32'd0;
      alu_op    = ADD;
      @(posedge clk); @(posedge clk); #1;

      // Reset state
      check_eq("rst in_ready",  {63'd0, in_ready},  64'd1);
      check_eq("rst out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst busy",      {63'd0, busy},      64'd0);
      check_eq("rst result",    {32'd0, result},    64'd0);
      check_eq("rst zero",      {63'd0, zero},      64'd1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single-cycle ops
      run_op("add",   ADD,  32'd5,          32'd7,          32'h0000000C, 1);
      run_op("sub",   SUB,  32'd7,          32'd7,          32'h00000000, 1);
      run_op("and",   AND,  32'hF0F0_FF00,  32'h0FF0_F0F0,  32'h00F0_F000, 1);
      run_op("or",    OR,   32'hF000_0001,  32'h0000_1000,  32'hF000_1001, 1);
      run_op("xor",   XOR,  32'hAAAA_5555,  32'hFFFF_0000,  32'h5555_5555, 1);
      run_op("slt",   SLT,  32'hFFFF_FFFF,  32'd1,          32'd1,         1);
      run_op("sltu",  SLTU, 32'hFFFF_FFFF,  32'd1,          32'd0,         1);
      run_op("sll",   SLL,  32'd1,          32'h0000_0021,  32'h0000_0002, 1);
      run_op("srl",   SRL,  32'h8000_0000,  32'd4,          32'h0800_0000, 1);
      run_op("sra",   SRA,  32'h8000_0000,  32'h0000_0024,  32'hF800_0000, 1);
      run_op("undef", alu_ops_t'(5'd31), 32'd9, 32'd9,      32'd0,         1);

      // Multiply
      run_op("mul",    MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 33);
      run_op("mulhu",  MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_op("mulh",   MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
      run_op("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
      run_op("mul6x7", MUL,    32'd6,         32'd7,         32'd42,        33);
      run_op("mulneg", MUL,    32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFF1, 33);
      run_op("mulhng", MULH,   32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 33);

      // Divide
      run_op("div-7/2",  DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
      run_op("rem-7/2",  REM,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
      run_op("div7/-2",  DIV,  32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
      run_op("rem7/-2",  REM,  32'd7,         32'hFFFF_FFFE, 32'd1,         33);
      run_op("divu",     DIVU, 32'd100,       32'd7,         32'd14,        33);
      run_op("remu",     REMU, 32'd100,       32'd7,         32'd2,         33);
      run_op("divu/0",   DIVU, 32'd7,         32'd0,         32'hFFFF_FFFF, 1);
      run_op("remu/0",   REMU, 32'd7,         32'd0,         32'd7,         1);
      run_op("div ovf",  DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
      run_op("rem ovf",  REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);

      // Backpressure: hold DONE for 5 cycles while a new request is offered
      operand_a = 32'd2;
      operand_b = 32'd3;
      alu_op    = ADD;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      operand_a = 32'd10;
      operand_b = 32'd20;
      for (int i = 0; i < 5; i++) begin
         check_eq("bp out_valid", {63'd0, out_valid}, 64'd1);
         check_eq("bp result",    {32'd0, result},    64'd5);
         check_eq("bp in_ready",  {63'd0, in_ready},  64'd0);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_eq("bp no same-cycle accept", {62'd0, out_valid, in_ready}, 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_eq("bp second valid",  {63'd0, out_valid}, 64'd1);
      check_eq("bp second result", {32'd0, result},    64'd30);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;

      // Reset in the middle of a division
      operand_a = 32'd100;
      operand_b = 32'd7;
      alu_op    = DIV;
      in_valid  = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 9; i++) begin
         @(posedge clk); #1;
      end
      check_eq("calc busy", {63'd0, busy}, 64'd1);
      rst_n = 1'b0;
      #1;
      check_eq("abort out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("abort in_ready",  {63'd0, in_ready},  64'd1);
      check_eq("abort busy",      {63'd0, busy},      64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      run_op("add after rst", ADD, 32'd1, 32'd1, 32'd2, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
